// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Default store/status addresses, status bit positions and FSM state encoding.
package mmio_pkg;

    localparam logic [31:0] DEF_DATA_ADDR   = 32'h0000_F000;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_F004;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_ACTIVE = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory store/load bus as seen by memory-mapped peripherals.
// The core drives the master side; peripherals such as the UART use the slave side.
interface mmio_uart_tx_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  DataAdr,
        input  WriteData,
        output ReadData
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock byte FIFO with occupancy count.
// Accepts a push while full only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem[rptr_q];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap by power-of-two width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to DATA_ADDR are queued and sent as 8N1.
// Defining MMIO_UART_TX_PARITY_EN adds an even-parity bit (8E1 frames).
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR    = DEF_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t    state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           ovf_q;
    logic           ovf_d;
`ifdef MMIO_UART_TX_PARITY_EN
    logic           par_q;
`endif

    logic           wr_data;
    logic           wr_stat;
    logic           f_pop;
    logic           f_full;
    logic           f_empty;
    logic [7:0]     f_dout;
    logic [FCW-1:0] f_count;
    logic           cnt_last;
    logic [31:0]    status;
    logic           unused_ok;

    assign wr_data  = bus.MemWrite && (bus.DataAdr == DATA_ADDR);
    assign wr_stat  = bus.MemWrite && (bus.DataAdr == STATUS_ADDR);
    assign f_pop    = (state_q == IDLE) && !f_empty;
    assign cnt_last = (cnt_q == CNT_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_data),
        .pop_i   (f_pop),
        .din_i   (bus.WriteData[7:0]),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );

    // Sticky overflow: set by a dropped push, clear has priority.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_data && f_full && !f_pop) begin
            ovf_d = 1'b1;
        end
        if (wr_stat && bus.WriteData[ST_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Serializer: tx_q is loaded with the level of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (state_q != IDLE) begin
                cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (!f_empty) begin
                        shift_q <= f_dout;
`ifdef MMIO_UART_TX_PARITY_EN
                        par_q   <= ^f_dout;
`endif
                        cnt_q   <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
`ifdef MMIO_UART_TX_PARITY_EN
                    if (cnt_last) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
`else
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
`endif
                end
                STOP: begin
                    if (cnt_last) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Status word assembly.
    always_comb begin
        status            = '0;
        status[ST_EMPTY]  = f_empty;
        status[ST_FULL]   = f_full;
        status[ST_OVF]    = ovf_q;
        status[ST_ACTIVE] = (state_q != IDLE);
    end

    assign bus.ReadData = (bus.DataAdr == STATUS_ADDR) ? status : 32'h0;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE) || !f_empty;
    assign unused_ok    = &{1'b0, bus.WriteData[31:8], f_count};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A mid-bit sampling receiver checks frame contents, spacing and busy timing.
module tb_mmio_uart_tx;
    import mmio_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .DATA_ADDR    (DEF_DATA_ADDR),
        .STATUS_ADDR  (DEF_STATUS_ADDR),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // One store, launched at a falling edge, captured by the next rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = a;
        bus.WriteData = d;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        bus.DataAdr = DEF_STATUS_ADDR;
        #1;
        v = bus.ReadData;
        bus.DataAdr = 32'h0;
    endtask

    // Waits for a start bit (bounded), then samples each bit in its middle.
    // gap = falling edges waited until the start bit was seen, -1 on timeout.
    task automatic rx_frame(output logic [7:0] b, output logic s,
                            output logic p, output logic e,
                            output int gap);
        b = 8'h0;
        s = 1'b1;
        p = 1'b0;
        e = 1'b0;
        gap = 0;
        while (gap < 400) begin
            @(negedge clk);
            gap++;
            if (tx === 1'b0) break;
        end
        if (tx !== 1'b0) begin
            gap = -1;
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        s = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
`ifdef MMIO_UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`endif
        repeat (CPB) @(negedge clk);
        e = tx;
    endtask

    task automatic test_reset();
        logic [31:0] st;
        reset = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx_in_reset: got %b want 1", tx);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        read_status(st);
        n_cmp++;
        if (st !== 32'h1) begin
            n_err++;
            $display("FAIL reset_status: got %h want 00000001", st);
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic s, p, e;
        int g;
        fork
            store(DEF_DATA_ADDR, 32'hDEAD_BE55);
            rx_frame(b, s, p, e, g);
        join
        n_cmp++;
        if (g !== 2) begin
            n_err++;
            $display("FAIL single_latency: got %0d want 2", g);
        end
        n_cmp++;
        if (s !== 1'b0) begin
            n_err++;
            $display("FAIL single_start: got %b want 0", s);
        end
        n_cmp++;
        if (b !== 8'h55) begin
            n_err++;
            $display("FAIL single_byte: got %h want 55", b);
        end
`ifdef MMIO_UART_TX_PARITY_EN
        n_cmp++;
        if (p !== 1'b0) begin
            n_err++;
            $display("FAIL single_parity: got %b want 0", p);
        end
`endif
        n_cmp++;
        if (e !== 1'b1) begin
            n_err++;
            $display("FAIL single_stop: got %b want 1", e);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy_last: got %b want 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy_end: got %b want 0", busy);
        end
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL single_tx_idle: got %b want 1", tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rb [3];
        logic       rs [3];
        logic       rp [3];
        logic       re [3];
        int         rg [3];
        int         want_g;
        repeat (5) @(negedge clk);
        fork
            begin
                store(DEF_DATA_ADDR, 32'h0000_0041);
                store(DEF_DATA_ADDR, 32'h0000_0042);
                store(DEF_DATA_ADDR, 32'h0000_0043);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    rx_frame(rb[k], rs[k], rp[k], re[k], rg[k]);
                end
            end
        join
        for (int k = 0; k < 3; k++) begin
            want_g = (k == 0) ? 2 : 3;
            n_cmp++;
            if (rg[k] !== want_g) begin
                n_err++;
                $display("FAIL b2b_gap%0d: got %0d want %0d", k, rg[k], want_g);
            end
            n_cmp++;
            if (rb[k] !== 8'(8'h41 + k)) begin
                n_err++;
                $display("FAIL b2b_byte%0d: got %h want %h", k, rb[k], 8'(8'h41 + k));
            end
            n_cmp++;
            if (rs[k] !== 1'b0 || re[k] !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_framing%0d: got start %b stop %b want 0 1", k, rs[k], re[k]);
            end
`ifdef MMIO_UART_TX_PARITY_EN
            n_cmp++;
            if (rp[k] !== ^rb[k]) begin
                n_err++;
                $display("FAIL b2b_parity%0d: got %b want %b", k, rp[k], ^rb[k]);
            end
`endif
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy_end: got %b want 0", busy);
        end
    endtask

    // Leaves 0x12..0x18 queued for the mid-frame reset test.
    task automatic test_overflow();
        logic [7:0]  b;
        logic        s, p, e;
        int          g;
        logic [31:0] st;
        repeat (5) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    store(DEF_DATA_ADDR, 32'hA5A5_A500 | 32'(8'h10 + i));
                end
            end
            rx_frame(b, s, p, e, g);
        join
        n_cmp++;
        if (g !== 2 || b !== 8'h10) begin
            n_err++;
            $display("FAIL ovf_first: got gap %0d byte %h want gap 2 byte 10", g, b);
        end
        read_status(st);
        n_cmp++;
        if (st !== 32'hE) begin
            n_err++;
            $display("FAIL ovf_status_set: got %h want 0000000e", st);
        end
        store(DEF_STATUS_ADDR, 32'h0000_0004);
        read_status(st);
        n_cmp++;
        if (st !== 32'hA) begin
            n_err++;
            $display("FAIL ovf_status_clr: got %h want 0000000a", st);
        end
        rx_frame(b, s, p, e, g);
        n_cmp++;
        if (g !== 2 || b !== 8'h11) begin
            n_err++;
            $display("FAIL ovf_second: got gap %0d byte %h want gap 2 byte 11", g, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] st;
        int          w;
        int          lows;
        int          busys;
        w = 0;
        while (w < 400 && tx !== 1'b0) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_start: got tx %b want 0", tx);
        end
        repeat (14) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_tx: got %b want 1", tx);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_busy: got %b want 0", busy);
        end
        read_status(st);
        n_cmp++;
        if (st !== 32'h1) begin
            n_err++;
            $display("FAIL rst_mid_status: got %h want 00000001", st);
        end
        bus.DataAdr = DEF_DATA_ADDR;
        #1;
        n_cmp++;
        if (bus.ReadData !== 32'h0) begin
            n_err++;
            $display("FAIL rd_other_addr: got %h want 00000000", bus.ReadData);
        end
        bus.DataAdr = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        lows  = 0;
        busys = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        n_cmp++;
        if (lows !== 0 || busys !== 0) begin
            n_err++;
            $display("FAIL rst_mid_quiet: got %0d low / %0d busy cycles want 0 / 0", lows, busys);
        end
    endtask

`ifdef MMIO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic s, p, e;
        int g;
        fork
            store(DEF_DATA_ADDR, 32'h0000_0007);
            rx_frame(b, s, p, e, g);
        join
        n_cmp++;
        if (b !== 8'h07 || p !== 1'b1) begin
            n_err++;
            $display("FAIL parity_07: got byte %h par %b want 07 1", b, p);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL parity_len: got busy %b want 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef MMIO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory side of the single-cycle RISC-V core. It sits beside `dmem` and consumes the core's store bus (`MemWrite`, `DataAdr`, `WriteData`). Bytes stored to its data address are buffered in a FIFO and serialized as 8N1 frames on `tx`. Programs use it to emit results without the bench peeking into the register file.

## Interface
- `DATA_ADDR`, default 32'h0000_F000, store target whose low byte is enqueued
- `STATUS_ADDR`, default 32'h0000_F004, status read and overflow-clear address
- `CLKS_PER_BIT`, default 868, clocks per serial bit (100 MHz / 115200); must be ≥ 2
- `FIFO_DEPTH`, default 8, byte entries; power of two, ≥ 2
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `MemWrite`  in  1  core store strobe, one cycle per store
- `DataAdr`  in  32  core data address
- `WriteData`  in  32  core store data
- `ReadData`  out  32  status word when `DataAdr == STATUS_ADDR`, else 0 (combinational)
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high while a frame is on the line or FIFO non-empty

## Operation
- Push: `MemWrite && DataAdr == DATA_ADDR` → `WriteData[7:0]` enqueued; upper bits ignored.
- Push when full (and no pop same cycle) → byte dropped, sticky `overflow` set.
- Push and pop in same cycle when full → both happen, no overflow.
- `MemWrite && DataAdr == STATUS_ADDR && WriteData[2]` → `overflow` cleared; clear wins over a same-cycle overflow set.
- Status word: bit0 `empty`, bit1 `full`, bit2 `overflow`, bit3 `active` (FSM not IDLE), bits 31:4 zero.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1; if FIFO non-empty → pop head into shift register, baud counter 0, go START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles → DATA, bit index 0.
  - DATA: `tx`=shift[0], LSB first; each bit `CLKS_PER_BIT` cycles; after bit 7 → STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles → IDLE.
- Baud counter width `$clog2(CLKS_PER_BIT)`; wraps to 0 at `CLKS_PER_BIT-1`, advancing the bit.
- FIFO count width `$clog2(FIFO_DEPTH+1)`; pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-frame: immediate abort, `tx` returns high asynchronously, FIFO emptied, bytes lost.

## Timing
- Reset values: `tx`=1, `busy`=0, FSM IDLE, FIFO empty, `overflow`=0, counters 0; `ReadData` at STATUS_ADDR reads 32'h1.
- `tx` is registered (driven from FSM state/shift register flops, no glitches).
- Push at edge N → `empty`=0 after N; with FSM idle, pop at N+1, `tx` falls after edge N+1.
- Frame length 10·`CLKS_PER_BIT` cycles (11 with parity); back-to-back frames separated by exactly one IDLE cycle.
- `busy` = FSM ≠ IDLE or FIFO non-empty; falls on the edge STOP→IDLE when FIFO empty.
- Store throughput: one push per cycle accepted until full.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP, `tx` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles; frame 11 bits.
- Undefined: no PARITY state, 8N1 frame of 10 bits.

## Structure
- Package `mmio_pkg`: default `DATA_ADDR`/`STATUS_ADDR` constants, status bit index localparams, `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module `sync_fifo` (parameterized width/depth, push/pop/full/empty/count); serializer FSM stays in `mmio_uart_tx`.

## Test plan
- Reset, then idle 20 cycles → `tx`=1, `busy`=0, status read 32'h1.
- `CLKS_PER_BIT`=4, store 32'hDEAD_BE55 to 0xF000 → `tx` sampled mid-bit: 0,1,0,1,0,1,0,1,0,1 (0x55 LSB first, start/stop), frame 40 cycles, `busy` falls after.
- Store 0x41,0x42,0x43 on consecutive cycles → three frames, one IDLE cycle between, bytes in order.
- `FIFO_DEPTH`=8, store 10 bytes in 10 cycles while first frame started → 9 accepted (one popped), 10th dropped, status bit2=1; store 32'h4 to 0xF004 → bit2=0.
- Assert `reset` mid DATA of a frame → `tx`=1 immediately, status 32'h1, no further frames.
- With `MMIO_UART_TX_PARITY_EN`, store 0x07 → parity bit 1, frame 44 cycles at `CLKS_PER_BIT`=4.
